// File: rtl/aec_expr_tx.sv
// aec_expr_tx: buffers 5-bit expression tokens and streams them as ASCII into the calculator, then returns its result.
// Optional syntax checking when AEC_EXPR_TX_PAREN_CHECK_EN is defined.
module aec_expr_tx #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_valid,
  input  logic [4:0] tok_data,
  output logic       tok_ready,
  output logic [7:0] ascii_out,
  output logic       ready,
  input  logic       valid,
  input  logic [6:0] result,
  output logic       res_valid,
  output logic [6:0] res_data,
  input  logic       res_ack,
  output logic       err
);
  localparam int W = $clog2(DEPTH);
  typedef enum logic [1:0] {LOAD, SEND, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0] ascii_q, ascii_d;
  logic ready_q, ready_d, res_valid_q, res_valid_d, err_q, err_d;
  logic [6:0] res_data_q, res_data_d;
  logic [4:0] mem_q [DEPTH];
  logic acc, is_eq, bad, wr_en;

  function automatic logic [7:0] char_of(input logic [4:0] t);
    return t < 5'd10 ? 8'h30 + {3'b0, t} :
           t < 5'd16 ? 8'h57 + {3'b0, t} :
           t < 5'd20 ? 8'h18 + {3'b0, t} :
           t == 5'd20 ? 8'h2D : 8'h3D;
  endfunction

`ifdef AEC_EXPR_TX_PAREN_CHECK_EN
  // last_q: 0 = start/operand, 1 = operator, 2 = open paren
  logic [W:0] depth_q, depth_d;
  logic [1:0] last_q, last_d;
  logic is_op, syn_err;
  always_comb begin
    is_op = tok_data inside {5'd18, 5'd19, 5'd20};
    syn_err = (tok_data == 5'd17 && depth_q == '0) || (is_eq && (depth_q != '0 || last_q != 2'd0)) ||
              (is_op && last_q == 2'd1);
    depth_d = !acc ? depth_q : (bad || is_eq) ? '0 :
              tok_data == 5'd16 ? depth_q + 1'b1 : tok_data == 5'd17 ? depth_q - 1'b1 : depth_q;
    last_d = !acc ? last_q : (bad || is_eq) ? 2'd0 : is_op ? 2'd1 : tok_data == 5'd16 ? 2'd2 : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      last_q <= 2'd0;
    end else begin
      depth_q <= depth_d;
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ascii_d = 8'h00;
    ready_d = 1'b0;
    err_d = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d = res_data_q;
    acc = tok_valid && state_q == LOAD;
    is_eq = tok_data == 5'd21;
    bad = tok_data > 5'd21 || (wr_ptr_q == W'(DEPTH - 1) && !is_eq)
`ifdef AEC_EXPR_TX_PAREN_CHECK_EN
          || syn_err
`endif
          ;
    wr_en = acc && !bad;
    case (state_q)
      LOAD: if (acc) begin
        err_d = bad;
        wr_ptr_d = (bad || is_eq) ? '0 : wr_ptr_q + 1'b1;
        // the first character may be the token being written this cycle
        if (!bad && is_eq) begin
          state_d = SEND;
          rd_ptr_d = W'(1);
          ascii_d = char_of(wr_ptr_q == '0 ? tok_data : mem_q[0]);
          ready_d = 1'b1;
        end
      end
      SEND: if (ascii_q == 8'h3D) state_d = WAIT;
      else begin
        ascii_d = char_of(mem_q[rd_ptr_q]);
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      WAIT: if (valid) begin
        state_d = DONE;
        res_valid_d = 1'b1;
        res_data_d = result;
      end
      DONE: if (res_ack) begin
        state_d = LOAD;
        res_valid_d = 1'b0;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ascii_q <= 8'h00;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ascii_q <= ascii_d;
      ready_q <= ready_d;
      err_q <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
    end
  end

  always_ff @(posedge clk) if (wr_en) mem_q[wr_ptr_q] <= tok_data;

  assign tok_ready = state_q == LOAD;
  assign ascii_out = ascii_q;
  assign ready = ready_q;
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign err = err_q;
endmodule

// File: tb/tb_aec_expr_tx.sv
// tb_aec_expr_tx: table-driven vectors plus directed error, overflow, reset and handshake sequences.
module tb_aec_expr_tx;
  logic clk = 1'b0, rst = 1'b1, tok_valid = 1'b0, valid = 1'b0, res_ack = 1'b0;
  logic [4:0] tok_data = '0;
  logic [6:0] result = '0;
  logic tok_ready, ready, res_valid, err;
  logic [7:0] ascii_out;
  logic [6:0] res_data;
  int pass = 0, total = 0;

  aec_expr_tx #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_data(tok_data), .tok_ready(tok_ready),
    .ascii_out(ascii_out), .ready(ready), .valid(valid), .result(result), .res_valid(res_valid),
    .res_data(res_data), .res_ack(res_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0][4:0] tok;
    logic [15:0][7:0] chr;
    int n;
    logic [6:0] res;
    bit hold;
  } vec_t;
  vec_t vt [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic feed(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      tok_valid = 1'b1;
      tok_data = v.tok[i];
      step();
    end
    tok_valid = v.hold;
    tok_data = 5'd1;
  endtask

  task automatic send_chk(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("char%0d", i), ascii_out, v.chr[i]);
      chk($sformatf("ready%0d", i), ready, i == 0);
      chk($sformatf("tok_ready_send%0d", i), tok_ready, 0);
      step();
    end
    chk("wait_ascii", ascii_out, 0);
    chk("wait_ready", ready, 0);
    chk("wait_tok_ready", tok_ready, 0);
  endtask

  task automatic to_done(input logic [6:0] r);
    step();
    chk("wait_res_valid", res_valid, 0);
    valid = 1'b1;
    result = r;
    step();
    valid = 1'b0;
    result = 7'h55;
    chk("done_res_valid", res_valid, 1);
    chk("done_res_data", res_data, r);
    chk("done_tok_ready", tok_ready, 0);
    step();
    chk("done_hold", res_data, r);
  endtask

  task automatic ack();
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    tok_valid = 1'b0;
    chk("ack_res_valid", res_valid, 0);
    chk("ack_tok_ready", tok_ready, 1);
  endtask

  task automatic run(input vec_t v);
    feed(v);
    send_chk(v);
    to_done(v.res);
    ack();
  endtask

  initial begin
    vt[0] = '{tok: 80'({5'd21, 5'd4, 5'd19, 5'd3}), chr: 128'({8'h3D, 8'h34, 8'h2B, 8'h33}),
              n: 4, res: 7'd7, hold: 1'b0};
    vt[1] = '{tok: 80'({5'd21, 5'd3, 5'd18, 5'd17, 5'd10, 5'd19, 5'd2, 5'd16}),
              chr: 128'({8'h3D, 8'h33, 8'h2A, 8'h29, 8'h61, 8'h2B, 8'h32, 8'h28}),
              n: 8, res: 7'd27, hold: 1'b1};
    vt[2] = '{tok: 80'({5'd21, 5'd14, 5'd20, 5'd15}), chr: 128'({8'h3D, 8'h65, 8'h2D, 8'h66}),
              n: 4, res: 7'd1, hold: 1'b0};
    vt[3] = '{tok: 80'(5'd21), chr: 128'(8'h3D), n: 1, res: 7'd0, hold: 1'b0};
    vt[4] = '{tok: {5'd21, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4,
                    5'd3, 5'd2, 5'd1, 5'd0},
              chr: {8'h3D, 8'h65, 8'h64, 8'h63, 8'h62, 8'h61, 8'h39, 8'h38, 8'h37, 8'h36, 8'h35,
                    8'h34, 8'h33, 8'h32, 8'h31, 8'h30},
              n: 16, res: 7'd127, hold: 1'b0};
    vt[5] = '{tok: 80'({5'd21, 5'd1}), chr: 128'({8'h3D, 8'h31}), n: 2, res: 7'd2, hold: 1'b0};
    step();
    step();
    rst = 1'b0;
    chk("rst_ascii", ascii_out, 0);
    chk("rst_ready", ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err, 0);
    chk("rst_tok_ready", tok_ready, 1);
    for (int k = 0; k < 5; k++) run(vt[k]);
    // illegal token then a normal expression
    tok_valid = 1'b1;
    tok_data = 5'd25;
    step();
    tok_valid = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_ascii", ascii_out, 0);
    step();
    chk("ill_err_clear", err, 0);
    chk("ill_ascii2", ascii_out, 0);
    run(vt[5]);
    // overflow: 16 tokens with no terminator
    for (int i = 0; i < 16; i++) begin
      tok_valid = 1'b1;
      tok_data = 5'd1;
      step();
      chk($sformatf("ovf_err%0d", i), err, i == 15);
    end
    tok_valid = 1'b0;
    step();
    chk("ovf_err_clear", err, 0);
    chk("ovf_no_send", ascii_out, 0);
    chk("ovf_tok_ready", tok_ready, 1);
`ifdef AEC_EXPR_TX_PAREN_CHECK_EN
    tok_valid = 1'b1;
    tok_data = 5'd17;
    step();
    chk("paren_err", err, 1);
    tok_data = 5'd21;
    step();
    tok_valid = 1'b0;
    chk("paren_eq_char", ascii_out, 8'h3D);
    chk("paren_err_clear", err, 0);
    step();
    to_done(7'd3);
    ack();
`else
    begin
      vec_t vp;
      vp = '{tok: 80'({5'd21, 5'd17}), chr: 128'({8'h3D, 8'h29}), n: 2, res: 7'd3, hold: 1'b0};
      run(vp);
    end
`endif
    // reset on the second SEND cycle of 5*6=
    begin
      vec_t vr;
      vr = '{tok: 80'({5'd21, 5'd6, 5'd18, 5'd5}), chr: 128'({8'h3D, 8'h36, 8'h2A, 8'h35}),
             n: 4, res: 7'd30, hold: 1'b0};
      feed(vr);
      chk("rs_first", ascii_out, 8'h35);
      step();
      chk("rs_second", ascii_out, 8'h2A);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rs_ascii", ascii_out, 0);
      chk("rs_ready", ready, 0);
      chk("rs_tok_ready", tok_ready, 1);
      valid = 1'b1;
      result = 7'd11;
      step();
      valid = 1'b0;
      chk("rs_no_res", res_valid, 0);
      step();
      chk("rs_no_res2", res_valid, 0);
      // valid and res_ack together in DONE
      feed(vr);
      send_chk(vr);
      to_done(7'h2A);
      valid = 1'b1;
      result = 7'd9;
      res_ack = 1'b1;
      step();
      valid = 1'b0;
      res_ack = 1'b0;
      chk("both_res_valid", res_valid, 0);
      chk("both_res_data", res_data, 7'h2A);
      chk("both_tok_ready", tok_ready, 1);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
